// File: rtl/nonce_dispatcher_if.sv
// Bundle of every control, core-side and status signal of the nonce
// dispatcher. The dispatcher connects through the master modport; the
// environment (controller plus hash cores, or a testbench) uses slave.
interface nonce_dispatcher_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int CIDX_W    = 2
);
    // run control
    logic                          start;
    logic                          abort;
    logic [NONCE_W-1:0]            start_nonce;
    logic [NONCE_W-1:0]            end_nonce;

    // hash-core side
    logic [NUM_CORES-1:0]          core_ready;
    logic [NUM_CORES-1:0]          core_issue;
    logic [NONCE_W-1:0]            core_nonce;
    logic [NUM_CORES-1:0]          core_done;
    logic [NUM_CORES-1:0]          core_hit;
    logic [NUM_CORES*NONCE_W-1:0]  core_result;

    // status
    logic                          busy;
    logic                          found;
    logic                          found_pulse;
    logic [NONCE_W-1:0]            found_nonce;
    logic [CIDX_W-1:0]             found_core;
    logic                          exhausted;
    logic [31:0]                   done_count;

    modport master (
        input  start, abort, start_nonce, end_nonce,
        input  core_ready, core_done, core_hit, core_result,
        output core_issue, core_nonce,
        output busy, found, found_pulse, found_nonce, found_core,
        output exhausted, done_count
    );

    modport slave (
        output start, abort, start_nonce, end_nonce,
        output core_ready, core_done, core_hit, core_result,
        input  core_issue, core_nonce,
        input  busy, found, found_pulse, found_nonce, found_core,
        input  exhausted, done_count
    );
endinterface

// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: hands out an inclusive nonce range one nonce per cycle
// to NUM_CORES hash cores in round-robin order, tracks how many nonces are
// still in flight, and reports either the first winning nonce (lowest core
// index wins a tie) or exhaustion of the range.
module nonce_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32,
    parameter int CIDX_W    = 2
) (
    input  logic               clock,
    input  logic               reset,
    nonce_dispatcher_if.master bus
);

    // in-flight counter width, enough to hold NUM_CORES
    localparam int CNT_W = $clog2(NUM_CORES + 1);
    localparam int OW    = CNT_W + 1;
    // one extra bit so rr_ptr + offset never overflows before the wrap
    localparam int PW    = CIDX_W + 1;
    // ready vector padded so a PW-bit index always lands inside it
    localparam int PAD   = 1 << PW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FOUND = 2'd2,
        EXH   = 2'd3
    } state_t;

    state_t               state;
    logic [NONCE_W-1:0]   next_nonce;
    logic [NONCE_W-1:0]   last_nonce;
    logic                 all_issued;
    logic [CIDX_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]     outstanding;
    logic [31:0]          done_count;
    logic [NONCE_W-1:0]   found_nonce;
    logic [CIDX_W-1:0]    found_core;
    logic                 found;
    logic                 found_pulse;
    logic                 exhausted;

    // ------------------------------------------------------------------
    // Round-robin grant: candidate k is core (rr_ptr + k) mod NUM_CORES,
    // and the lowest k with a ready core wins.
    // ------------------------------------------------------------------
    logic [PAD-1:0]       ready_pad;
    logic [PW-1:0]        cand_idx [NUM_CORES];
    logic [NUM_CORES-1:0] cand_ready;
    logic                 grant_valid;
    logic [CIDX_W-1:0]    grant_idx;
    logic                 issue_en;
    logic [NUM_CORES-1:0] issue_vec;

    assign ready_pad = PAD'(bus.core_ready);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_cand
            logic [PW-1:0] sum;
            assign sum            = {1'b0, rr_ptr} + PW'(gi);
            assign cand_idx[gi]   = (sum >= PW'(NUM_CORES)) ? (sum - PW'(NUM_CORES)) : sum;
            assign cand_ready[gi] = ready_pad[cand_idx[gi]];
        end
    endgenerate

    // pick the first ready candidate counting up from rr_ptr
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (cand_ready[k]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k][CIDX_W-1:0];
            end
        end
    end

    // issuing is only possible while a run still has nonces left
    assign issue_en = (state == RUN) && !all_issued && grant_valid;

    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_issue
            assign issue_vec[gi] = issue_en && (grant_idx == CIDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result collection
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     done_pop;
    logic                 hit_valid;
    logic [CIDX_W-1:0]    hit_idx;
    logic [NONCE_W-1:0]   hit_nonce;

    // number of cores reporting completion this cycle
    always_comb begin
        done_pop = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            done_pop = done_pop + CNT_W'(bus.core_done[k]);
        end
    end

    // lowest-index core with a qualified hit wins
    always_comb begin
        hit_valid = 1'b0;
        hit_idx   = '0;
        hit_nonce = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (bus.core_done[k] && bus.core_hit[k]) begin
                hit_valid = 1'b1;
                hit_idx   = CIDX_W'(k);
                hit_nonce = bus.core_result[k*NONCE_W +: NONCE_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter next values. The in-flight count floors at zero so a
    // spurious done pulse cannot wrap it into a huge value.
    // ------------------------------------------------------------------
    logic [OW-1:0]        out_plus;
    logic [CNT_W-1:0]     out_next;
    logic [32:0]          dc_sum;
    logic [31:0]          dc_next;
    logic [CIDX_W-1:0]    rr_next;

    assign out_plus = {1'b0, outstanding} + OW'(issue_en);
    assign out_next = (out_plus > {1'b0, done_pop}) ? CNT_W'(out_plus - {1'b0, done_pop}) : '0;
    assign dc_sum   = {1'b0, done_count} + 33'(done_pop);
    assign dc_next  = dc_sum[32] ? 32'hFFFF_FFFF : dc_sum[31:0];
    assign rr_next  = (grant_idx == CIDX_W'(NUM_CORES - 1)) ? '0 : (grant_idx + CIDX_W'(1));

    // ------------------------------------------------------------------
    // Control FSM and all run state. Priority: abort, then hit, then
    // exhaustion; start is only looked at outside RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            next_nonce  <= '0;
            last_nonce  <= '0;
            all_issued  <= 1'b0;
            rr_ptr      <= '0;
            outstanding <= '0;
            done_count  <= '0;
            found_nonce <= '0;
            found_core  <= '0;
            found       <= 1'b0;
            found_pulse <= 1'b0;
            exhausted   <= 1'b0;
        end else begin
            found_pulse <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                found       <= 1'b0;
                exhausted   <= 1'b0;
                outstanding <= '0;
            end else begin
                case (state)
                    RUN: begin
                        outstanding <= out_next;
                        done_count  <= dc_next;
                        if (issue_en) begin
                            rr_ptr <= rr_next;
                            // ">=" also ends a reversed range after its first nonce
                            if (next_nonce >= last_nonce) begin
                                all_issued <= 1'b1;
                            end else begin
                                next_nonce <= next_nonce + NONCE_W'(1);
                            end
                        end
                        if (hit_valid) begin
                            found_nonce <= hit_nonce;
                            found_core  <= hit_idx;
                            found       <= 1'b1;
                            found_pulse <= 1'b1;
                            state       <= FOUND;
                        end else if (all_issued && (out_next == '0)) begin
                            exhausted <= 1'b1;
                            state     <= EXH;
                        end
                    end
                    default: begin
                        if (bus.start) begin
                            next_nonce  <= bus.start_nonce;
                            last_nonce  <= bus.end_nonce;
                            all_issued  <= 1'b0;
                            outstanding <= '0;
                            done_count  <= '0;
                            rr_ptr      <= '0;
                            found       <= 1'b0;
                            exhausted   <= 1'b0;
                            state       <= RUN;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.core_issue  = issue_vec;
    assign bus.core_nonce  = next_nonce;
    assign bus.busy        = (state == RUN);
    assign bus.found       = found;
    assign bus.found_pulse = found_pulse;
    assign bus.found_nonce = found_nonce;
    assign bus.found_core  = found_core;
    assign bus.exhausted   = exhausted;
    assign bus.done_count  = done_count;

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Multi-core work distributor between the processor's mining control registers and N SHA-256d hash cores; successor to the single-core miner control path.
- Splits an inclusive nonce range [start_nonce, end_nonce] across NUM_CORES cores, one nonce per issue, using round-robin issue.
- Collects per-core results, reports the first winning nonce and its core index, or reports range exhaustion.
- Runs on the mining clock domain; processor- and UART-side synchronisation is outside this block.

Parameters:
NUM_CORES, 4, number of hash cores served (1..16)
NONCE_W, 32, nonce width in bits
CIDX_W, 2, core-index width; must be >= clog2(NUM_CORES) and >= 1

Ports:
clock  input  1  mining clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  pulse; samples start_nonce and end_nonce, begins a run
abort  input  1  level/pulse; ends the current run and returns to IDLE
start_nonce  input  NONCE_W  first nonce of the range (inclusive)
end_nonce  input  NONCE_W  last nonce of the range (inclusive)
core_ready  input  NUM_CORES  core i can accept a nonce
core_issue  output  NUM_CORES  one-hot, combinational; a nonce transfers to core i on an edge where core_issue[i] is high
core_nonce  output  NONCE_W  broadcast nonce, valid while any core_issue bit is high
core_done  input  NUM_CORES  1-cycle pulse: core i has finished one nonce
core_hit  input  NUM_CORES  qualified by core_done[i]; the result met the target
core_result  input  NUM_CORES*NONCE_W  nonce tested by core i; slice [i*NONCE_W +: NONCE_W]; valid with core_done[i]
busy  output  1  state == RUN
found  output  1  level; a winning nonce is held
found_pulse  output  1  1-cycle pulse on entry to FOUND
found_nonce  output  NONCE_W  latched winning nonce
found_core  output  CIDX_W  index of the winning core
exhausted  output  1  level; range fully tested with no hit
done_count  output  32  nonces completed in the current run; saturates at 32'hFFFFFFFF

Behaviour:
- States: IDLE, RUN, FOUND, EXH. Encoding is free; no other states exist.
- Reset values: state IDLE; next_nonce, rr_ptr, outstanding, done_count, found_nonce and found_core all 0; all_issued 0; found, found_pulse and exhausted 0; core_issue 0.
- Priority within a cycle: reset > abort > hit > exhaustion > start.
- abort, in any state: go to IDLE; clear found, exhausted and outstanding; found_nonce and done_count keep their values.
- start is honoured only in IDLE, FOUND or EXH. On that edge:
  - next_nonce <= start_nonce; latch end_nonce; all_issued <= 0; outstanding <= 0; done_count <= 0; rr_ptr <= 0.
  - clear found and exhausted; enter RUN.
  - start asserted while in RUN is ignored.
- Issue (RUN and !all_issued only):
  - core_issue = one-hot of the first ready core, searching from rr_ptr upward and wrapping; at most one issue per cycle. First possible issue is the cycle after start.
  - On an issue edge: rr_ptr <= granted index + 1, wrapping to 0 after NUM_CORES-1.
  - If next_nonce == latched end, set all_issued; otherwise next_nonce <= next_nonce + 1. No wrap past 2^NONCE_W-1 can occur.
  - If end < start: issue start_nonce only, then treat the range as done (single-nonce run).
- Accounting in RUN: outstanding <= outstanding + (issue?1:0) - popcount(core_done). done_count += popcount(core_done), saturating. Width of outstanding is clog2(NUM_CORES+1).
- Hit: any i with core_done[i] & core_hit[i] in RUN.
  - The lowest such i wins: found_nonce <= core_result slice i; found_core <= i; found <= 1; found_pulse high for the next cycle only; enter FOUND.
  - A hit that arrives on the same edge as exhaustion goes to FOUND.
  - core_hit without core_done is ignored.
- Exhaustion: in RUN, all_issued and the outstanding count after this cycle's update == 0 -> exhausted <= 1, enter EXH.
- In IDLE, FOUND and EXH: core_issue = 0; core_done and core_hit are ignored; counters are frozen.
- core_done and core_issue to the same core in the same cycle are legal.
- core_nonce = next_nonce at all times. It is meaningful only while an issue bit is set.

Test Plan:
- NUM_CORES=4, all cores ready, cores return done 3 cycles after issue with no hit, range 0x10..0x17 -> core_issue grants cores 0,1,2,3,0,1,2,3 with nonces 0x10..0x17 in order; exhausted rises after the 8th done; done_count=8; found=0.
- Same setup, core 2 hits on nonce 0x12 -> found_pulse for exactly 1 cycle; found_nonce=0x12; found_core=2; no issue after the hit edge; later dones leave done_count unchanged.
- Cores 1 and 3 assert done+hit in the same cycle with results 0xA1 and 0xA3 -> found_core=1, found_nonce=0xA1.
- Range 0xFFFFFFFE..0xFFFFFFFF -> exactly 2 issues; no wrap to 0; exhausted after 2 dones.
- abort asserted mid-run with 3 nonces outstanding, then start with range 0x100..0x100 -> IDLE with found=0 and exhausted=0; new run issues 0x100 once; late done pulses from the aborted run are ignored while in IDLE.
- reset asserted asynchronously mid-run between clock edges -> busy, core_issue and found go to 0 immediately; start, abort and hit pulses during reset have no effect.
